// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial two's-complement adder/subtractor, LSB first,
// one full-adder cell with a registered carry; WIDTH+1 cycles START to DONE.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   START, SUB    request (taken when READY=1), 0: A+B / 1: A-B
//   A, B          WIDTH-bit operands, sampled with START
//   READY         high only while idle
//   DONE          one-cycle pulse, RESULT/COUT/OVF valid
//   RESULT        sum/difference mod 2^WIDTH
//   COUT          add: carry-out; sub: 1 = no borrow (A >= B unsigned)
//   OVF           signed overflow
//
// Optional feature: define SERIAL_ADD_SUB_OVF_EN to build the signed
// overflow flag; otherwise OVF is tied low and no MSB-carry state exists.

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             OVF
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-2:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;

`ifdef SERIAL_ADD_SUB_OVF_EN
    logic             c_msb;
    logic             ovf_q;
`endif

    logic             sum_bit;
    logic             carry_nxt;
    logic             last;
    logic [WIDTH-1:0] acc_nxt;

    always_comb begin
        sum_bit   = op_a[0] ^ op_b[0] ^ carry;
        carry_nxt = (op_a[0] & op_b[0]) | (op_b[0] & carry) | (op_a[0] & carry);
        last      = (cnt == CW'(WIDTH - 1));
        // New bit enters at the top; the low bits drop into place by the
        // time the MSB step completes, so acc_nxt is the full result then.
        acc_nxt   = {sum_bit, acc};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            c_msb    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        op_a  <= A;
                        // Subtract as A + ~B + 1: invert B, seed carry.
                        op_b  <= B ^ {WIDTH{SUB}};
                        carry <= SUB;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    carry <= carry_nxt;
                    acc   <= acc_nxt[WIDTH-1:1];
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    cnt   <= cnt + CW'(1);
`ifdef SERIAL_ADD_SUB_OVF_EN
                    // Carry leaving bit WIDTH-2 is the carry into the MSB.
                    if (cnt == CW'(WIDTH - 2)) begin
                        c_msb <= carry_nxt;
                    end
`endif
                    if (last) begin
                        result_q <= acc_nxt;
                        cout_q   <= carry_nxt;
`ifdef SERIAL_ADD_SUB_OVF_EN
                        ovf_q    <= c_msb ^ carry_nxt;
`endif
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign READY  = (state == S_IDLE);
    assign DONE   = (state == S_DONE);
    assign RESULT = result_q;
    assign COUT   = cout_q;

`ifdef SERIAL_ADD_SUB_OVF_EN
    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed scoreboard bench for serial_add_sub (WIDTH=8).
// Driver queues expected results; a negedge monitor checks every DONE.

module tb_serial_add_sub;

    localparam int W = 8;

`ifdef SERIAL_ADD_SUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic         SUB;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         READY;
    logic         DONE;
    logic [W-1:0] RESULT;
    logic         COUT;
    logic         OVF;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        int           start;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_n   = 0;
    int   done_cnt = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .SUB    (SUB),
        .A      (A),
        .B      (B),
        .READY  (READY),
        .DONE   (DONE),
        .RESULT (RESULT),
        .COUT   (COUT),
        .OVF    (OVF)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                done_cnt++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got DONE=1 expected none (edge %0d)",
                             edge_n);
                end else begin
                    e = sbq.pop_front();
                    chk("result", RESULT, e.res);
                    chk("cout", COUT, e.c);
                    chk("ovf", OVF, e.o);
                    chk("latency", edge_n + 1 - e.start, W + 1);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge CLK);
        while (READY !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (READY !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got READY=%b expected 1", READY);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] r,
                         input logic c, input logic o);
        exp_t e;
        wait_ready();
        START = 1'b1;
        A     = a;
        B     = b;
        SUB   = sub;
        e = '{res: r, c: c, o: o & OVF_ON, start: edge_n + 1};
        sbq.push_back(e);
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_pending", sbq.size(), 0);
    endtask

    initial begin
        int   d0;
        int   t0;
        exp_t e;

        RST   = 1'b1;
        START = 1'b0;
        SUB   = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", READY, 1);
        chk("rst_done", DONE, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_cout", COUT, 0);
        chk("rst_ovf", OVF, 0);

        issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        wait_drain();

        // Reset while idle clears held outputs.
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("idle_rst_ready", READY, 1);
        chk("idle_rst_result", RESULT, 0);
        chk("idle_rst_cout", COUT, 0);
        chk("idle_rst_ovf", OVF, 0);

        issue(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        issue(8'hA5, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0);
        wait_drain();

        // START pulsed during RUN must be ignored.
        issue(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        chk("ready_in_run", READY, 0);
        START = 1'b1;
        A     = 8'h01;
        B     = 8'h01;
        SUB   = 1'b0;
        @(posedge CLK);
        #1 START = 1'b0;
        wait_drain();
        repeat (12) @(negedge CLK);

        // START held for 30 cycles: accepted every W+2 cycles.
        wait_ready();
        d0    = done_cnt;
        START = 1'b1;
        A     = 8'h5A;
        B     = 8'h3C;
        SUB   = 1'b0;
        t0    = edge_n + 1;
        for (int k = 0; k < 3; k++) begin
            e = '{res: 8'h96, c: 1'b0, o: OVF_ON, start: t0 + k * (W + 2)};
            sbq.push_back(e);
        end
        repeat (30) @(posedge CLK);
        #1 START = 1'b0;
        wait_drain();
        repeat (12) @(negedge CLK);
        chk("held_done_count", done_cnt - d0, 3);

        // Abort: reset on the 4th RUN edge, no DONE afterwards.
        wait_ready();
        d0    = done_cnt;
        START = 1'b1;
        A     = 8'h33;
        B     = 8'h11;
        SUB   = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("abort_ready", READY, 1);
        chk("abort_done", DONE, 0);
        chk("abort_result", RESULT, 0);
        chk("abort_cout", COUT, 0);
        repeat (12) @(negedge CLK);
        chk("abort_no_done", done_cnt - d0, 0);

        issue(8'h33, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0);
        wait_drain();
        repeat (3) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
